// File: rtl/sub_shift_col.sv
// sub_shift_col: serial SubBytes + ShiftRows stage feeding the 32-bit column mixer.
// A 128-bit state is accepted in IDLE, substituted one column per cycle in SUB
// through four shared S-boxes, then emitted row-shifted as four 32-bit columns in OUT.
// Optional build macro: INV_CIPHER_EN adds the in_inv port, inverse S-boxes and
// inverse ShiftRows ordering, selected per state at accept time.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid && ready are both high. in_ready is high only in IDLE. out_valid is high
// only in OUT, and while out_valid && !out_ready, out_col/out_idx/out_last hold.
// out_ready is ignored outside OUT, and in_valid is ignored outside IDLE.
module sub_shift_col (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
`ifdef INV_CIPHER_EN
   input  logic         in_inv,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_col,
   output logic [1:0]   out_idx,
   output logic         out_last,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      OUT  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [127:0]  st_q, st_d;
`ifdef INV_CIPHER_EN
   logic          inv_q, inv_d;
`endif

   logic [31:0]   sub_col;
   logic [31:0]   shift_col;

   // ---------------------------------------------------------------------
   // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1.
   // The S-box is computed algebraically (multiplicative inverse followed by
   // the affine map) rather than tabulated; inverse of 0 is defined as 0.
   // ---------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 == x^-1 for nonzero x, via a short square-and-multiply chain.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127;
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      return gf_mul(x127, x127);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

`ifdef INV_CIPHER_EN
   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      logic [7:0] b;
      b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
      return gf_inv(b);
   endfunction
`endif

   // Byte at column c, row r; column c occupies [127-32c -: 32], row 0 is its MSB.
   function automatic logic [7:0] byte_at(input logic [127:0] st, input logic [1:0] c,
                                          input int r);
      return st[127 - 32*int'(c) - 8*r -: 8];
   endfunction

   // Four shared S-boxes applied to the column selected by the sub counter.
   always_comb begin
      sub_col = 32'h0;
      for (int r = 0; r < 4; r++) begin
`ifdef INV_CIPHER_EN
         if (inv_q) sub_col[31 - 8*r -: 8] = sbox_inv(byte_at(st_q, cnt_q, r));
         else       sub_col[31 - 8*r -: 8] = sbox_fwd(byte_at(st_q, cnt_q, r));
`else
         sub_col[31 - 8*r -: 8] = sbox_fwd(byte_at(st_q, cnt_q, r));
`endif
      end
   end

   // ShiftRows gather: row r of the output column comes from column idx+r
   // (forward) or idx-r (inverse), 2-bit wrap-around.
   always_comb begin
      shift_col = 32'h0;
      for (int r = 0; r < 4; r++) begin
`ifdef INV_CIPHER_EN
         if (inv_q) shift_col[31 - 8*r -: 8] = byte_at(st_q, idx_q - 2'(r), r);
         else       shift_col[31 - 8*r -: 8] = byte_at(st_q, idx_q + 2'(r), r);
`else
         shift_col[31 - 8*r -: 8] = byte_at(st_q, idx_q + 2'(r), r);
`endif
      end
   end

   // Next-state logic: accept in IDLE, one column per cycle in SUB, drain in OUT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      st_d    = st_q;
`ifdef INV_CIPHER_EN
      inv_d   = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_state;
               cnt_d   = 2'd0;
               idx_d   = 2'd0;
`ifdef INV_CIPHER_EN
               inv_d   = in_inv;
`endif
               state_d = SUB;
            end
         end
         SUB: begin
            st_d[127 - 32*int'(cnt_q) -: 32] = sub_col;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               idx_d   = 2'd0;
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset drops any in-flight state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         idx_q   <= 2'd0;
         st_q    <= 128'h0;
`ifdef INV_CIPHER_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
`ifdef INV_CIPHER_EN
         inv_q   <= inv_d;
`endif
      end
   end

   // Handshake and output decode; out_col is forced to zero when not valid.
   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == OUT);
      out_idx     = idx_q;
      out_col     = out_valid ? shift_col : 32'h0;
      out_last    = out_valid && (idx_q == 2'd3);
      dbg_state_o = state_q;
   end

endmodule
